control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 32 +++
 rtl/control_sequencer.sv | 68 ++++++
 tb/tb_control_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/memory inputs and datapath control strobes of the sequencer.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_done;
    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Zin;
    logic        Zlowout;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Run;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [4:0]  alu_op;

    modport master (
        input  ir, mem_done,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, Run,
        output r_in, r_out, alu_op
    );

    modport slave (
        output ir, mem_done,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, Run,
        input  r_in, r_out, alu_op
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM fetching an instruction and sequencing three-register ALU ops.
module control_sequencer (
    input  logic             clk,
    input  logic             reset,
    control_sequencer_if.master bus
);
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_T0    = 3'd1;
    localparam logic [2:0] S_T1    = 3'd2;
    localparam logic [2:0] S_T2    = 3'd3;
    localparam logic [2:0] S_T3    = 3'd4;
    localparam logic [2:0] S_T4    = 3'd5;
    localparam logic [2:0] S_T5    = 3'd6;
    localparam logic [2:0] S_HALT  = 3'd7;

    logic [2:0] state, state_nxt;
    logic       t1_wait;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       alu_instr;

    assign opcode    = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign alu_instr = opcode inside {5'b00011, 5'b00100, 5'b01001, 5'b01010};

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_T0;
            S_T0:    state_nxt = S_T1;
            S_T1:    state_nxt = bus.mem_done ? S_T2 : S_T1;
            S_T2:    state_nxt = alu_instr ? S_T3 : (opcode == 5'b11011) ? S_HALT : S_T0;
            S_T3:    state_nxt = S_T4;
            S_T4:    state_nxt = S_T5;
            S_T5:    state_nxt = S_T0;
            default: state_nxt = S_HALT;
        endcase
    end

    // t1_wait marks every T1 cycle after the first so PC is loaded only once
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RESET;
            t1_wait <= 1'b0;
        end else begin
            state   <= state_nxt;
            t1_wait <= state == S_T1;
        end
    end

    assign bus.PCout   = state == S_T0;
    assign bus.MARin   = state == S_T0;
    assign bus.IncPC   = state == S_T0;
    assign bus.Zin     = state == S_T0 || state == S_T4;
    assign bus.Zlowout = state == S_T1 || state == S_T5;
    assign bus.PCin    = state == S_T1 && !t1_wait;
    assign bus.Read    = state == S_T1;
    assign bus.MDRin   = state == S_T1;
    assign bus.MDRout  = state == S_T2;
    assign bus.IRin    = state == S_T2;
    assign bus.Yin     = state == S_T3;
    assign bus.Run     = state != S_RESET && state != S_HALT;
    assign bus.r_out   = state == S_T3 ? 16'h1 << rb : state == S_T4 ? 16'h1 << rc : 16'h0;
    assign bus.r_in    = state == S_T5 ? 16'h1 << ra : 16'h0;
    assign bus.alu_op  = state == S_T4 ? opcode : 5'b0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: per-instruction expected-output timeline model with randomized instructions.
module tb_control_sequencer;
    localparam logic [11:0] PCOUT = 12'h800, MARIN = 12'h400, INCPC = 12'h200, ZIN = 12'h100;
    localparam logic [11:0] ZLOW = 12'h080, PCIN = 12'h040, READ = 12'h020, MDRIN = 12'h010;
    localparam logic [11:0] MDROUT = 12'h008, IRIN = 12'h004, YIN = 12'h002, RUN = 12'h001;
    localparam logic [48:0] ZERO = 49'h0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if bus();
    control_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    logic [48:0] dut_v, exp_v;
    bit          exp_valid = 1'b0;
    int          errors = 0, checks = 0;
    logic [48:0] trace[$];

    assign dut_v = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin, bus.Read,
                    bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Run, bus.r_in, bus.r_out, bus.alu_op};

    function automatic logic [48:0] mk(logic [11:0] c, logic [15:0] ri, logic [15:0] ro, logic [4:0] op);
        return {c, ri, ro, op};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got ctrl=%h r_in=%h r_out=%h alu_op=%h want ctrl=%h r_in=%h r_out=%h alu_op=%h",
                         $time, dut_v[48:37], dut_v[36:21], dut_v[20:5], dut_v[4:0],
                         exp_v[48:37], exp_v[36:21], exp_v[20:5], exp_v[4:0]);
            end
            checks++;
            if (!($onehot0(bus.r_in) && $onehot0(bus.r_out) && (bus.r_in == 16'h0 || bus.r_out == 16'h0))) begin
                errors++;
                $display("FAIL onehot t=%0t got r_in=%h r_out=%h want exclusive one-hot", $time, bus.r_in, bus.r_out);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    task automatic cycle(input logic [48:0] e, input logic md);
        exp_v = e;
        exp_valid = 1'b1;
        bus.mem_done = md;
        @(negedge clk);
        trace.push_back(dut_v);
        @(posedge clk);
        #1;
    endtask

    function automatic logic noise_bit(input bit noise);
        return noise && ($urandom_range(0, 1) == 1);
    endfunction

    // Expected timeline of one instruction: fetch, w extra T1 waits, then execute if ALU op
    task automatic instr(input logic [31:0] irv, input int w, input bit noise, input bit abort);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit alu;
        op = irv[31:27];
        ra = irv[26:23];
        rb = irv[22:19];
        rc = irv[18:15];
        alu = op == 5'd3 || op == 5'd4 || op == 5'd9 || op == 5'd10;
        bus.ir = irv;
        cycle(mk(PCOUT | MARIN | INCPC | ZIN | RUN, 16'h0, 16'h0, 5'h0), noise_bit(noise));
        for (int i = 0; i <= w; i++)
            cycle(mk(ZLOW | (i == 0 ? PCIN : 12'h0) | READ | MDRIN | RUN, 16'h0, 16'h0, 5'h0), i == w);
        cycle(mk(MDROUT | IRIN | RUN, 16'h0, 16'h0, 5'h0), noise_bit(noise));
        if (!alu) return;
        cycle(mk(YIN | RUN, 16'h0, 16'h1 << rb, 5'h0), noise_bit(noise));
        if (abort) begin
            reset = 1'b1;
            cycle(mk(ZIN | RUN, 16'h0, 16'h1 << rc, op), noise_bit(noise));
            reset = 1'b0;
            cycle(ZERO, noise_bit(noise));
            return;
        end
        cycle(mk(ZIN | RUN, 16'h0, 16'h1 << rc, op), noise_bit(noise));
        cycle(mk(ZLOW | RUN, 16'h1 << ra, 16'h0, 5'h0), noise_bit(noise));
    endtask

    initial begin
        int s;
        logic [4:0] op;
        bus.ir = 32'h0;
        bus.mem_done = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        repeat (2) cycle(ZERO, $urandom_range(0, 1) == 1);
        reset = 1'b0;
        cycle(ZERO, 1'b0);
        chk("first_t0_pcout", bus.PCout, 1);

        s = trace.size();
        instr(32'h4A920000, 0, 0, 0);
        chk("and_t3_rout", trace[s + 3][20:5], 16'h0004);
        chk("and_t4_rout", trace[s + 4][20:5], 16'h0010);
        chk("and_t4_aluop", trace[s + 4][4:0], 5'b01001);
        chk("and_t5_rin", trace[s + 5][36:21], 16'h0020);
        chk("and_then_t0", bus.PCout, 1);

        s = trace.size();
        instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'h0}, 3, 0, 0);
        chk("wait_pcin_first", trace[s + 1][43], 1);
        for (int i = 2; i <= 4; i++) chk("wait_pcin_later", trace[s + i][43], 0);
        for (int i = 1; i <= 4; i++) chk("wait_read", trace[s + i][42], 1);
        for (int i = 1; i <= 4; i++) chk("wait_mdrin", trace[s + i][41], 1);
        chk("wait_then_t2", trace[s + 5][39], 1);

        s = trace.size();
        instr({5'b00011, 4'd7, 4'd7, 4'd7, 15'h1234}, 0, 1, 0);
        chk("r7_t3_rout", trace[s + 3][20:5], 16'h0080);
        chk("r7_t4_rout", trace[s + 4][20:5], 16'h0080);
        chk("r7_t5_rin", trace[s + 5][36:21], 16'h0080);

        instr({5'b11111, 27'h5A5A5A5}, 1, 1, 0);
        chk("nop_then_t0", bus.PCout, 1);

        s = trace.size();
        instr({5'b00100, 4'd9, 4'd3, 4'd12, 15'h0}, 0, 1, 1);
        chk("abort_reset_rin", trace[s + 4][36:21], 16'h0);
        chk("abort_then_t0", bus.PCout, 1);

        s = trace.size();
        instr({5'b11011, 27'h0}, 1, 1, 0);
        repeat (20) cycle(ZERO, $urandom_range(0, 1) == 1);
        chk("halt_run", trace[s + 4][37], 0);
        reset = 1'b1;
        cycle(ZERO, 1'b1);
        reset = 1'b0;
        cycle(ZERO, 1'b0);
        chk("halt_reset_t0", bus.PCout, 1);

        repeat (40) begin
            case ($urandom_range(0, 5))
                0: op = 5'b00011;
                1: op = 5'b00100;
                2: op = 5'b01001;
                3: op = 5'b01010;
                default: begin
                    op = 5'($urandom_range(0, 31));
                    if (op == 5'b11011) op = 5'b00000;
                end
            endcase
            instr({op, 27'($urandom)}, $urandom_range(0, 3), 1, $urandom_range(0, 7) == 0);
        end

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
